// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the step-driven MIPS pipeline:
//   - default datapath / register-number widths
//   - data-memory access width encodings (MEM_BYTE / MEM_HALF / MEM_WORD)
//   - helpers that turn an access width and byte lane into alignment and
//     byte-enable information
// The width encoding 2'b10 has no instruction of its own and is handled
// exactly like MEM_WORD everywhere.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int NB_DEFAULT     = 32;
  localparam int NB_REG_DEFAULT = 5;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // Word-sized access: the real word encoding and the spare 2'b10 code.
  function automatic logic is_word(input logic [1:0] width);
    return (width == MEM_WORD) || (width == 2'b10);
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic lane_misaligned(input logic [1:0] width,
                                           input logic [1:0] lane);
    if (is_word(width)) begin
      return lane != 2'b00;
    end else if (width == MEM_HALF) begin
      return lane[0];
    end
    return 1'b0;
  endfunction

  // Byte enables of a 32-bit word touched by an aligned access.
  function automatic logic [3:0] lane_enables(input logic [1:0] width,
                                              input logic [1:0] lane);
    if (is_word(width)) begin
      return 4'b1111;
    end else if (width == MEM_HALF) begin
      return 4'b0011 << lane;
    end
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// -----------------------------------------------------------------------------
// ex_mem_stage_if
// Pipeline-side bundle of the memory stage: everything EXECUTE hands over
// (i_*) and everything the stage hands to write-back (o_*).
//   master : the upstream / test side, drives i_*, observes o_*
//   slave  : ex_mem_stage itself, observes i_*, drives o_*
// Parameters NB / NB_REG must match those of the ex_mem_stage it is bound to.
// -----------------------------------------------------------------------------
interface ex_mem_stage_if #(
  parameter int NB     = mips_pkg::NB_DEFAULT,
  parameter int NB_REG = mips_pkg::NB_REG_DEFAULT
);

  // EXECUTE -> MEM
  logic [NB-1:0]     i_alu_result;
  logic [NB-1:0]     i_data_b;
  logic              i_mem_read;
  logic              i_mem_write;
  logic [1:0]        i_mem_width;
  logic              i_mem_unsigned;
  logic              i_reg_write;
  logic              i_mem_to_reg;
  logic [NB_REG-1:0] i_write_reg;

  // MEM -> WRITE-BACK
  logic [NB-1:0]     o_wb_read_data;
  logic [NB-1:0]     o_wb_alu_result;
  logic [NB_REG-1:0] o_wb_write_reg;
  logic              o_wb_reg_write;
  logic              o_wb_mem_to_reg;
  logic              o_misaligned;

  modport master (
    output i_alu_result, i_data_b, i_mem_read, i_mem_write, i_mem_width,
           i_mem_unsigned, i_reg_write, i_mem_to_reg, i_write_reg,
    input  o_wb_read_data, o_wb_alu_result, o_wb_write_reg, o_wb_reg_write,
           o_wb_mem_to_reg, o_misaligned
  );

  modport slave (
    input  i_alu_result, i_data_b, i_mem_read, i_mem_write, i_mem_width,
           i_mem_unsigned, i_reg_write, i_mem_to_reg, i_write_reg,
    output o_wb_read_data, o_wb_alu_result, o_wb_write_reg, o_wb_reg_write,
           o_wb_mem_to_reg, o_misaligned
  );

endinterface

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised data RAM with per-byte write enables.
//   i_clk          : clock
//   i_wr_be        : byte-lane write enables (all zero = no write)
//   i_index        : word index shared by the write port and the read port
//   i_wr_data      : write data, already replicated onto the enabled lanes
//   o_rd_data      : combinational read of word i_index (pre-write contents
//                    during the cycle a write is pending)
// Only when MEM_DEBUG_PORT_EN is defined:
//   i_reset        : synchronous active-high reset of the debug read register
//   i_debug_index  : word index for the debug unit
//   o_debug_data   : registered read of word i_debug_index, every clock
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int NB      = 32,
  parameter int TAM_MEM = 64
) (
  input  logic                       i_clk,
`ifdef MEM_DEBUG_PORT_EN
  input  logic                       i_reset,
  input  logic [$clog2(TAM_MEM)-1:0] i_debug_index,
  output logic [NB-1:0]              o_debug_data,
`endif
  input  logic [NB/8-1:0]            i_wr_be,
  input  logic [$clog2(TAM_MEM)-1:0] i_index,
  input  logic [NB-1:0]              i_wr_data,
  output logic [NB-1:0]              o_rd_data
);

  logic [NB-1:0] mem [TAM_MEM];

  assign o_rd_data = mem[i_index];

  // NOTE: the array has no reset branch on purpose; a reset loop over every
  // word would stop this mapping onto block RAM. Contents survive i_reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB/8; b++) begin
      if (i_wr_be[b]) begin
        // NOTE: sequential state is written with <= only, so every reader
        // in this edge (including the debug port) sees the pre-write value.
        mem[i_index][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  // Second read port: runs on every clock so the debug unit can dump
  // memory while the pipeline is halted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_debug_data <= '0;
    end else begin
      o_debug_data <= mem[i_debug_index];
    end
  end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
// Memory stage of the step-driven MIPS pipeline: EX/MEM latch, little-endian
// byte/half/word data memory, MEM/WB latch and a sticky misalignment flag.
//   i_clk            : clock
//   i_reset          : synchronous, active-high; wins over i_step
//   i_step           : pipeline advance enable; nothing changes while low
//   i_debug_mem_addr : word index for the debug read port
//   o_debug_mem_data : registered debug read (1 clock latency, ignores i_step)
//   bus              : ex_mem_stage_if.slave, EXECUTE inputs / WB outputs
// Build option:
//   MEM_DEBUG_PORT_EN : when defined, the debug read port exists (second RAM
//                       read port); otherwise o_debug_mem_data is tied to 0.
// Timing: an instruction captured at step edge N commits its store and
// presents its write-back values at step edge N+1. All outputs registered.
// -----------------------------------------------------------------------------
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int NB      = NB_DEFAULT,
  parameter int TAM_MEM = 64,
  parameter int NB_REG  = NB_REG_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_step,
  input  logic [NB-1:0] i_debug_mem_addr,
  output logic [NB-1:0] o_debug_mem_data,
  ex_mem_stage_if.slave bus
);

  localparam int IDX_W = $clog2(TAM_MEM);

  // EX/MEM latch
  logic [NB-1:0]     ex_alu_result;
  logic [NB-1:0]     ex_data_b;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [1:0]        ex_mem_width;
  logic              ex_mem_unsigned;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic [NB_REG-1:0] ex_write_reg;

  // MEM/WB latch
  logic [NB-1:0]     wb_read_data;
  logic [NB-1:0]     wb_alu_result;
  logic [NB_REG-1:0] wb_write_reg;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic              misaligned;

  // Address decode of the latched access. Bits above the index are dropped,
  // so addresses wrap around the memory.
  logic [IDX_W-1:0] ex_index;
  logic [1:0]       ex_lane;
  logic             ex_misaligned;

  assign ex_index      = ex_alu_result[IDX_W+1:2];
  assign ex_lane       = ex_alu_result[1:0];
  assign ex_misaligned = (ex_mem_read || ex_mem_write) &&
                         lane_misaligned(ex_mem_width, ex_lane);

  // Memory port signals
  logic [NB/8-1:0] wr_be;
  logic [NB-1:0]   wr_data;
  logic [NB-1:0]   rd_word;

  // A store commits on the step edge that moves it out of EX/MEM; a reset on
  // that same edge discards it.
  assign wr_be = (i_step && !i_reset && ex_mem_write && !ex_misaligned)
               ? lane_enables(ex_mem_width, ex_lane) : '0;

  // Store data is replicated across the word; the byte enables pick the lanes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves it unassigned (which would infer a latch).
    wr_data = ex_data_b;
    if (ex_mem_width == MEM_BYTE) begin
      wr_data = {4{ex_data_b[7:0]}};
    end else if (ex_mem_width == MEM_HALF) begin
      wr_data = {2{ex_data_b[15:0]}};
    end
  end

  // Load lane selection and extension. The read is combinational off the
  // latched index, so a simultaneous store in the same instruction still
  // returns the pre-write contents.
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [NB-1:0] load_data;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (ex_lane)
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = ex_lane[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    if (ex_mem_read && !ex_misaligned) begin
      if (ex_mem_width == MEM_BYTE) begin
        load_data = {{(NB-8){byte_sel[7] & ~ex_mem_unsigned}}, byte_sel};
      end else if (ex_mem_width == MEM_HALF) begin
        load_data = {{(NB-16){half_sel[15] & ~ex_mem_unsigned}}, half_sel};
      end else begin
        load_data = rd_word;
      end
    end
  end

  // Both pipeline latches and the sticky flag advance together on a step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_alu_result   <= '0;
      ex_data_b       <= '0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_mem_width    <= MEM_BYTE;
      ex_mem_unsigned <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_write_reg    <= '0;
      wb_read_data    <= '0;
      wb_alu_result   <= '0;
      wb_write_reg    <= '0;
      wb_reg_write    <= 1'b0;
      wb_mem_to_reg   <= 1'b0;
      misaligned      <= 1'b0;
    end else if (i_step) begin
      ex_alu_result   <= bus.i_alu_result;
      ex_data_b       <= bus.i_data_b;
      ex_mem_read     <= bus.i_mem_read;
      ex_mem_write    <= bus.i_mem_write;
      ex_mem_width    <= bus.i_mem_width;
      ex_mem_unsigned <= bus.i_mem_unsigned;
      ex_reg_write    <= bus.i_reg_write;
      ex_mem_to_reg   <= bus.i_mem_to_reg;
      ex_write_reg    <= bus.i_write_reg;
      wb_read_data    <= load_data;
      wb_alu_result   <= ex_alu_result;
      wb_write_reg    <= ex_write_reg;
      wb_reg_write    <= ex_reg_write;
      wb_mem_to_reg   <= ex_mem_to_reg;
      if (ex_misaligned) begin
        misaligned <= 1'b1;
      end
    end
  end

  assign bus.o_wb_read_data  = wb_read_data;
  assign bus.o_wb_alu_result = wb_alu_result;
  assign bus.o_wb_write_reg  = wb_write_reg;
  assign bus.o_wb_reg_write  = wb_reg_write;
  assign bus.o_wb_mem_to_reg = wb_mem_to_reg;
  assign bus.o_misaligned    = misaligned;

  data_memory #(
    .NB      (NB),
    .TAM_MEM (TAM_MEM)
  ) u_data_memory (
    .i_clk         (i_clk),
`ifdef MEM_DEBUG_PORT_EN
    .i_reset       (i_reset),
    .i_debug_index (i_debug_mem_addr[IDX_W-1:0]),
    .o_debug_data  (o_debug_mem_data),
`endif
    .i_wr_be       (wr_be),
    .i_index       (ex_index),
    .i_wr_data     (wr_data),
    .o_rd_data     (rd_word)
  );

`ifdef MEM_DEBUG_PORT_EN
  // Debug index bits above the memory depth are ignored (wrap).
  logic unused_debug_addr_bits;
  assign unused_debug_addr_bits = ^i_debug_mem_addr[NB-1:IDX_W];
`else
  logic unused_debug_addr;
  assign unused_debug_addr = ^i_debug_mem_addr;
  assign o_debug_mem_data  = '0;
`endif

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Memory stage of the step-driven MIPS pipeline, placed directly downstream of EXECUTE. It holds the EX/MEM pipeline register, a byte-addressable little-endian data memory with byte/half/word access, and the MEM/WB pipeline register that feeds write-back. A side read port lets the debug unit dump data-memory words over UART while the pipeline is halted.

## Interface
Parameters:
- NB, 32: datapath width.
- TAM_MEM, 64: data-memory depth in 32-bit words; must be a power of two.
- NB_REG, 5: register-number width.

Ports:
- i_clk, in, 1: system clock; the only clock.
- i_reset, in, 1: synchronous, active-high reset.
- i_step, in, 1: pipeline advance enable from the debug unit; no register or memory state changes while low.
- i_alu_result, in, NB: ALU result from EXECUTE; used as the byte address for loads and stores.
- i_data_b, in, NB: store data (rt).
- i_mem_read / i_mem_write, in, 1 each: load / store request.
- i_mem_width, in, 2: 00 = byte, 01 = half, 11 = word; 10 is treated as word.
- i_mem_unsigned, in, 1: zero-extend loads (LBU/LHU).
- i_reg_write / i_mem_to_reg, in, 1 each: write-back controls, passed through.
- i_write_reg, in, NB_REG: destination register, passed through.
- i_debug_mem_addr, in, NB: word index requested by the debug unit.
- o_debug_mem_data, out, NB: word at that index.
- o_wb_read_data, out, NB: extended load data.
- o_wb_alu_result, out, NB: ALU result, delayed.
- o_wb_write_reg, out, NB_REG; o_wb_reg_write, out, 1; o_wb_mem_to_reg, out, 1.
- o_misaligned, out, 1: sticky misaligned-access flag.

## Operation
- EX/MEM latch: on an edge with i_step=1, it captures all i_* pipeline inputs.
- Address decode on latched values:
  - word index = addr[log2(TAM_MEM)+1:2]; upper address bits are ignored, so addresses wrap.
  - lane = addr[1:0].
- Misaligned access: a half access with lane[0]=1, or a word access with lane≠0, counts as misaligned when mem_read or mem_write is set. In that case:
  - the write is suppressed;
  - read data is forced to 0;
  - o_misaligned is set at the commit edge and held until reset.
- Store, committed at the next i_step edge:
  - byte: data_b[7:0] into lane.
  - half: data_b[15:0] into lanes lane, lane+1.
  - word: the full word.
  - Other lanes are untouched.
- Load: the lane is selected from the word read combinationally at the latched index.
  - Byte: sign-extend from bit 7, or zero-extend if unsigned.
  - Half: extend from bit 15 likewise.
  - Word: i_mem_unsigned is ignored.
  - Non-load instructions: o_wb_read_data = 0.
- mem_read and mem_write both set: the store is performed, and the read returns the pre-write contents (read-before-write).
- MEM/WB latch: on an edge with i_step=1, it captures the load data, alu_result, write_reg, reg_write and mem_to_reg from the EX/MEM latch.
- Reset:
  - both latches clear; all o_wb_* = 0 and o_misaligned = 0.
  - o_debug_mem_data = 0 until the next clock.
  - Memory contents are not cleared by reset; they are zero at power-up.
  - A store pending in EX/MEM when reset asserts is discarded.
  - i_reset has priority over i_step on the same edge.

## Timing
- Two-step latency: inputs are captured at step edge N, memory writes and o_wb_* update at step edge N+1.
- Back-to-back steps stream one instruction per step. A load immediately after a store to the same word reads the stored value, because the write commits at the edge where the load enters EX/MEM.
- All outputs are registered; there are no combinational input-to-output paths.
- With i_step held low, o_wb_* and memory are frozen indefinitely.
- Debug port: registered every i_clk regardless of i_step, 1-cycle latency. The index uses the low log2(TAM_MEM) bits.

## Configuration
- MEM_DEBUG_PORT_EN defined: the debug read port is implemented as above (second RAM read port).
- Not defined:
  - o_debug_mem_data is tied to 0;
  - i_debug_mem_addr is unused;
  - the memory is single-read-port.
  - Pipeline behaviour is identical in both builds.

## Structure
- Shared package mips_pkg: MEM_BYTE/MEM_HALF/MEM_WORD width encodings, NB and NB_REG defaults.
- One sub-module, data_memory. It is a byte-lane-write-enabled RAM with:
  - one combinational read port;
  - one registered debug read port under MEM_DEBUG_PORT_EN.
- Pipeline latches, lane selection, extension and misalignment logic stay in ex_mem_stage.

## Test plan
- Store word then load word: SW 0xDEADBEEF to addr 8, then LW addr 8 → o_wb_read_data=0xDEADBEEF two steps after LW entry.
- Byte and half loads:
  - LB addr 9 → 0xFFFFFFBE; LBU addr 9 → 0x000000BE.
  - SH 0x00001234 to addr 10, then LW addr 8 → 0x1234BEEF.
- Misaligned access: LW addr 6 and SH addr 5 → o_misaligned=1 stays high, read data 0, and a debug read of words 1/2 shows no change.
- Step gating: vary all inputs with i_step=0 for 20 cycles → o_wb_* and memory unchanged; the debug port still tracks i_debug_mem_addr with 1-cycle latency.
- Reset mid-operation: assert i_reset on the edge where a pending SW 0x55 to addr 0 would commit (i_step=1) → word 0 unchanged, all o_wb_*=0, o_misaligned=0.
- Address wrap: SW 0xA5A5A5A5 to addr 4*TAM_MEM+4 → debug read of word 1 = 0xA5A5A5A5.
